// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a single
// GF(2^8) column datapath, four cycles per 128-bit state, start/done handshake.
module inv_mix_columns_seq (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         start,
   input  logic [127:0] data_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] data_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t         fsm_q;
   fsm_t         fsm_next;
   logic [127:0] state_q;
   logic [127:0] state_next;
   logic [1:0]   col_q;
   logic [1:0]   col_next;

   logic [31:0]  col_in;
   logic [31:0]  col_out;
   logic [7:0]   row_in  [4];
   logic [7:0]   row_out [4];

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul09(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x;
   endfunction

   function automatic logic [7:0] mul0b(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ x;
   endfunction

   function automatic logic [7:0] mul0d(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x;
   endfunction

   function automatic logic [7:0] mul0e(input logic [7:0] x);
      logic [7:0] x2, x4, x8;
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Column currently being transformed; column 0 sits in the top 32 bits.
   always_comb begin
      col_in = state_q[127:96];
      case (col_q)
         2'd0:    col_in = state_q[127:96];
         2'd1:    col_in = state_q[95:64];
         2'd2:    col_in = state_q[63:32];
         default: col_in = state_q[31:0];
      endcase
   end

   // Each output row uses the same coefficient row {0e,0b,0d,09} rotated by its index.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_row
         assign row_in[gi]  = col_in[31-8*gi -: 8];
         assign row_out[gi] = mul0e(row_in[gi])
                            ^ mul0b(row_in[(gi+1)%4])
                            ^ mul0d(row_in[(gi+2)%4])
                            ^ mul09(row_in[(gi+3)%4]);
      end
   endgenerate

   assign col_out = {row_out[0], row_out[1], row_out[2], row_out[3]};

   always_comb begin
      fsm_next   = fsm_q;
      state_next = state_q;
      col_next   = col_q;
      case (fsm_q)
         IDLE: begin
            if (start) begin
               state_next = data_in;
               col_next   = 2'd0;
               fsm_next   = RUN;
            end
         end
         RUN: begin
            case (col_q)
               2'd0:    state_next[127:96] = col_out;
               2'd1:    state_next[95:64]  = col_out;
               2'd2:    state_next[63:32]  = col_out;
               default: state_next[31:0]   = col_out;
            endcase
            col_next = col_q + 2'd1;
            if (col_q == 2'd3) begin
               fsm_next = DONE;
            end
         end
         DONE: begin
            // Holding here until start drops guarantees one op per start assertion.
            if (!start) begin
               fsm_next = IDLE;
            end
         end
         default: begin
            fsm_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fsm_q   <= IDLE;
         state_q <= 128'd0;
         col_q   <= 2'd0;
      end else begin
         fsm_q   <= fsm_next;
         state_q <= state_next;
         col_q   <= col_next;
      end
   end

   assign busy     = (fsm_q == RUN);
   assign done     = (fsm_q == DONE);
   assign data_out = state_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: known vectors, handshake and
// reset corner cases, and random states against a matrix-product reference.
module tb_inv_mix_columns_seq;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         start;
   logic [127:0] data_in;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   int n_checks = 0;
   int n_fails  = 0;

   inv_mix_columns_seq dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .start    (start),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string        name;
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [3];

   // Reference: generic GF(2^8) multiply (shift-and-add mod 0x11b) and matrix product.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
      logic [7:0]   coef [4];
      logic [7:0]   b    [16];
      logic [7:0]   acc;
      logic [127:0] r = 128'd0;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - row + 4) % 4], b[4*c+j]);
            r[127-8*(4*c+row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Drives start with data at a negedge; returns one negedge after the accepting edge, start still high.
   task automatic start_op(input logic [127:0] d);
      @(negedge CLK);
      data_in = d;
      start   = 1'b1;
      @(negedge CLK);
   endtask

   // Waits (bounded) for done; lat counts negedges from the first post-accept sample.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cycles++;
         @(negedge CLK);
         lat++;
      end
   endtask

   logic [127:0] d, d2, expv;
   int lat, bc, dc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"fips197",   128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c};
      vecs[1] = '{"fixedpt",   128'hc6c6c6c6_01010101_00000000_ffffffff, 128'hc6c6c6c6_01010101_00000000_ffffffff};
      vecs[2] = '{"col2_d5d5", 128'h00000000_00000000_d5d5d7d6_00000000, 128'h00000000_00000000_d4d4d4d5_00000000};

      RESET = 1'b1; start = 1'b0; data_in = '0;
      repeat (3) @(negedge CLK);
      chk("reset_data_out", data_out, 128'd0);
      chk("reset_busy", {127'd0, busy}, 128'd0);
      chk("reset_done", {127'd0, done}, 128'd0);
      RESET = 1'b0;

      // Table-driven known vectors with latency and busy-width checks.
      for (int i = 0; i < 3; i++) begin
         start_op(vecs[i].din);
         start = 1'b0;
         wait_done(lat, bc);
         chk({vecs[i].name, "_latency"}, 128'(lat), 128'd4);
         chk({vecs[i].name, "_busy_cycles"}, 128'(bc), 128'd4);
         chk({vecs[i].name, "_result"}, data_out, vecs[i].exp);
         @(negedge CLK);
         chk({vecs[i].name, "_done_clears"}, {127'd0, done}, 128'd0);
      end

      // Mid-run view plus start/data_in toggling during RUN.
      d = {$urandom, $urandom, $urandom, $urandom};
      expv = ref_inv_mix(d);
      start_op(d);
      start = 1'b0;
      @(negedge CLK);
      start = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      chk("midrun_cols01_done", data_out, {expv[127:64], d[63:0]});
      start = 1'b0; data_in = {$urandom, $urandom, $urandom, $urandom};
      wait_done(lat, bc);
      chk("midrun_latency_rest", 128'(lat), 128'd2);
      chk("midrun_result", data_out, expv);
      @(negedge CLK);

      // start held high for 10 cycles: one op only, done held until start drops.
      d = {$urandom, $urandom, $urandom, $urandom};
      start_op(d);
      bc = 0; dc = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy) bc++;
         if (done) dc++;
         @(negedge CLK);
      end
      chk("hold_busy_cycles", 128'(bc), 128'd4);
      chk("hold_done_cycles", 128'(dc), 128'd6);
      chk("hold_done_still", {127'd0, done}, 128'd1);
      chk("hold_result", data_out, ref_inv_mix(d));
      start = 1'b0;
      @(negedge CLK);
      chk("hold_release_idle", {126'd0, busy, done}, 128'd0);
      @(negedge CLK);
      chk("hold_no_restart", {126'd0, busy, done}, 128'd0);

      // Reset after two RUN edges, together with a competing start.
      d = {$urandom, $urandom, $urandom, $urandom};
      start_op(d);
      start = 1'b0;
      @(negedge CLK);
      RESET = 1'b1; start = 1'b1; data_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      chk("midreset_data_out", data_out, 128'd0);
      chk("midreset_flags", {126'd0, busy, done}, 128'd0);
      RESET = 1'b0; start = 1'b0;
      start_op(vecs[0].din);
      start = 1'b0;
      wait_done(lat, bc);
      chk("after_reset_fips", data_out, vecs[0].exp);
      @(negedge CLK);

      // Back-to-back ops with a one-edge start-low gap.
      d  = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom, $urandom};
      start_op(d);
      wait_done(lat, bc);
      chk("b2b_first", data_out, ref_inv_mix(d));
      start = 1'b0;
      @(negedge CLK);
      chk("b2b_gap_idle", {126'd0, busy, done}, 128'd0);
      data_in = d2; start = 1'b1;
      @(negedge CLK);
      chk("b2b_second_accepted", {127'd0, busy}, 128'd1);
      start = 1'b0;
      wait_done(lat, bc);
      chk("b2b_second", data_out, ref_inv_mix(d2));
      @(negedge CLK);

      // Random states against the reference model.
      for (int i = 0; i < 20; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         start_op(d);
         start = 1'b0;
         data_in = ~d;
         wait_done(lat, bc);
         chk($sformatf("rand%0d", i), data_out, ref_inv_mix(d));
         @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Iterative AES InvMixColumns stage for the decryption datapath. It transforms one 32-bit state column per clock over four cycles. It sits directly upstream of the InvShiftRows stage in the round loop: round n ends with InvMixColumns, and its result feeds round n+1's InvShiftRows. The round controller drives it with a start/done handshake, so only one small GF(2^8) column datapath is needed instead of four.

Parameters:
None. Fixed AES-128 state, 128 bits, 4 columns of 4 bytes.

Ports:
CLK       input   1    system clock; all state updates on rising edge
RESET     input   1    synchronous, active-high reset
start     input   1    request; sampled only in IDLE
data_in   input   128  state to transform; sampled on the accepted start edge
busy      output  1    high in RUN
done      output  1    high in DONE; held until start deasserts
data_out  output  128  transformed state (working register)

Behaviour:
- State layout: byte k = data_in[127-8k -: 8]. Column c = bytes 4c..4c+3 = bits [127-32c -: 32]. Byte 4c is row 0.
- Column op, rows r0..r3 in, s0..s3 out:
  - s0 = 0e*r0 ^ 0b*r1 ^ 0d*r2 ^ 09*r3
  - s1 = 09*r0 ^ 0e*r1 ^ 0b*r2 ^ 0d*r3
  - s2 = 0d*r0 ^ 09*r1 ^ 0e*r2 ^ 0b*r3
  - s3 = 0b*r0 ^ 0d*r1 ^ 09*r2 ^ 0e*r3
- GF(2^8) arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - 09 = x8 ^ x
  - 0b = x8 ^ x2 ^ x
  - 0d = x8 ^ x4 ^ x
  - 0e = x8 ^ x4 ^ x2
  - All products 8 bits, no carries.
- Registers: 128-bit state_q (drives data_out), 2-bit col_q, FSM {IDLE, RUN, DONE}.
- FSM transitions:
  - IDLE: on edge with start=1: state_q <= data_in, col_q <= 0, -> RUN. Otherwise state_q holds.
  - RUN: each edge replaces column col_q of state_q with its transform; col_q <= col_q+1. On the edge processing col_q==3 -> DONE. Columns are processed strictly in order 0,1,2,3; untouched columns hold.
  - DONE: state_q holds. -> IDLE on first edge with start=0. Stays in DONE while start=1.
- Latency: start sampled at edge k -> done=1 after edge k+4. data_out is final and stable from then until the next accepted start.
- busy = (state==RUN); done = (state==DONE); both registered-state decodes, no combinational path from start.
- start is ignored in RUN. data_in is ignored except on the accepted edge; changing it mid-run has no effect.
- start held high continuously: exactly one operation per start assertion; a new op needs start low for at least one edge, passing through IDLE.
- RESET (any state, including mid-RUN): next edge -> IDLE, state_q=0, col_q=0, busy=0, done=0, data_out=0. RESET wins over simultaneous start.

Test Plan:
- FIPS-197 vector: data_in=8e4da1bc_9fdc589d_01010101_4d7ebdf8, pulse start -> done 4 cycles after the accepted edge; data_out=db135345_f20a225c_01010101_2d26314c.
- Fixed points: data_in=c6c6c6c6_01010101_00000000_ffffffff -> same value out. Separately, d5d5d7d6 in column 2 -> d4d4d4d5.
- Mid-run observation: after the edge processing column 1, data_out column 0 and column 1 are transformed while columns 2 and 3 still equal data_in. busy=1 for exactly 4 cycles.
- Handshake: hold start high 10 cycles -> exactly one op, done stays 1 until start drops, IDLE next edge. Toggle start and data_in during RUN -> result unaffected.
- Reset mid-operation: assert RESET after 2 RUN cycles -> data_out=0, busy=0, done=0. A fresh start then produces the correct vector result.
- Back-to-back: two ops with different inputs separated by a 1-cycle start-low gap -> both results correct; second start is accepted only from IDLE.
